// File: rtl/fetch_pkg.sv
// Shared types and reset defaults for the instruction fetch front end.
package fetch_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular queue of fetch entries; the head is visible combinationally.
// Latency: a pushed entry reaches the head one cycle after the push.
// Backpressure: push while full is accepted only with a same-cycle pop; flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_dat,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_dat;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: issues sequential word fetches, queues returns with PC, flushes on redirect.
// Latency: memory response to instr_valid is 1 cycle; 0 when FETCH_BYPASS_EN is defined.
// Backpressure: issue stops once queued + in-flight reaches DEPTH; out_ready low holds the head.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            out_ready,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4
);
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     CAP     = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   w_drop_nxt;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_dat;
    logic            w_rsp;
    logic            w_rsp_live;
    logic            w_byp;
    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_credit;

    // A response with nothing outstanding is spurious and ignored.
    assign w_rsp      = imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_live = w_rsp && (r_state == FETCH) && !redirect_valid;
`ifdef FETCH_BYPASS_EN
    assign w_byp      = w_rsp_live && w_empty;
`else
    assign w_byp      = 1'b0;
`endif
    assign w_push     = w_rsp_live && !(w_byp && out_ready);
    assign w_pop      = !w_empty && out_ready;
    assign w_credit   = ({1'b0, w_count} + {1'b0, r_outstanding}) < CAP;
    assign w_issue    = imem_req_valid && imem_req_ready;
    assign w_push_dat = '{pc: r_resp_pc, instr: imem_rsp_data};
    assign imem_req_addr = r_fetch_pc;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_dat   (w_push_dat),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Responses still in flight at a redirect belong to the old path and are dropped.
    always_comb begin
        w_state_nxt    = r_state;
        w_drop_nxt     = r_drop_cnt;
        imem_req_valid = 1'b0;
        if (redirect_valid) begin
            w_drop_nxt  = r_outstanding - CW'(w_rsp);
            w_state_nxt = (w_drop_nxt != '0) ? DRAIN : FETCH;
        end else begin
            case (r_state)
                IDLE:  w_state_nxt = FETCH;
                FETCH: imem_req_valid = w_credit;
                DRAIN: begin
                    if (w_rsp) w_drop_nxt = r_drop_cnt - CW'(1);
                    if (w_drop_nxt == '0) w_state_nxt = FETCH;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_drop_cnt    <= w_drop_nxt;
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_rsp);
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
            end else begin
                if (w_issue)    r_fetch_pc <= r_fetch_pc + PC_STEP;
                if (w_rsp_live) r_resp_pc  <= r_resp_pc + PC_STEP;
            end
        end
    end

    always_comb begin
        instr_valid = !w_empty;
        instr       = w_empty ? '0 : w_head.instr;
        instr_pc    = w_empty ? '0 : w_head.pc;
        if (w_byp) begin
            instr_valid = 1'b1;
            instr       = imem_rsp_data;
            instr_pc    = r_resp_pc;
        end
    end

    assign instr_pc_plus4 = instr_valid ? (instr_pc + PC_STEP) : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && w_full && !w_pop));
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: in-order memory model feeding an expected-instruction scoreboard.
module tb_fetch_prefetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_LAT = 2;
`else
    localparam int FIRST_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        out_ready      = 1'b1;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t     mem_q[$];
    fetch_entry_t exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           mem_lat  = 1;
    int           hs_cnt   = 0;
    int           pop_cnt  = 0;
    int           first_iv = -1;
    int           rel      = 0;
    logic [31:0]  model_pc = RST_PC;
    logic [31:0]  hs_first_addr = 32'hDEAD_BEEF;
    logic [31:0]  first_pop_pc  = 32'hDEAD_BEEF;
    bit           wrap_seen = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: observe at negedge, update models, then drive the next cycle's memory response.
    task automatic step();
        fetch_entry_t e;
        @(negedge clk);
        if (instr_valid && first_iv < 0) first_iv = cyc;
        if (redirect_valid) check_val("no_req_on_redirect", 32'(imem_req_valid), 0);
        if (imem_req_valid) check_val("credit_limit", 32'(exp_q.size() < DEPTH), 1);
        if (instr_valid && out_ready && !redirect_valid) begin
            check_val("pop_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("instr_pc", instr_pc, e.pc);
                check_val("instr", instr, e.instr);
                check_val("instr_pc_plus4", instr_pc_plus4, e.pc + 32'd4);
                if (e.pc == 32'hFFFF_FFFC) begin
                    wrap_seen = 1'b1;
                    check_val("wrap_plus4", instr_pc_plus4, 0);
                end
                if (pop_cnt == 0) first_pop_pc = instr_pc;
                pop_cnt++;
            end
        end
        if (redirect_valid) begin
            exp_q.delete();
            model_pc = redirect_pc;
        end
        if (imem_req_valid && imem_req_ready) begin
            check_val("req_addr", imem_req_addr, model_pc);
            e.pc    = model_pc;
            e.instr = mem_word(model_pc);
            exp_q.push_back(e);
            mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            if (hs_cnt == 0) hs_first_addr = imem_req_addr;
            model_pc = model_pc + 32'd4;
            hs_cnt++;
        end
        if (imem_rsp_valid) void'(mem_q.pop_front());
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end
    endtask

    // Asserts reset between clock edges and checks the outputs respond without a clock.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check_val("rst_req_valid", 32'(imem_req_valid), 0);
        check_val("rst_instr_valid", 32'(instr_valid), 0);
        check_val("rst_instr", instr, 0);
        check_val("rst_instr_pc", instr_pc, 0);
        check_val("rst_pc_plus4", instr_pc_plus4, 0);
        mem_q.delete();
        exp_q.delete();
        model_pc       = RST_PC;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        hs_cnt         = 0;
        pop_cnt        = 0;
        first_iv       = -1;
        hs_first_addr  = 32'hDEAD_BEEF;
        first_pop_pc   = 32'hDEAD_BEEF;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rel = cyc;
    endtask

    // Two fetches outstanding on a 3-cycle memory, then a redirect; leaves the DUT in its drain cycle.
    task automatic redirect_with_two_outstanding(input logic [31:0] target);
        mem_lat        = 3;
        out_ready      = 1'b1;
        imem_req_ready = 1'b0;
        do_reset();
        step();
        imem_req_ready = 1'b1;
        for (int i = 0; i < 10 && hs_cnt < 2; i++) step();
        check_val("two_outstanding", hs_cnt, 2);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        pop_cnt        = 0;
        step();
    endtask

    initial begin
        // Streaming from reset with a 1-cycle memory
        mem_lat = 1;
        do_reset();
        repeat (12) step();
        check_val("first_valid_latency", first_iv - rel, FIRST_LAT);
        check_val("stream_pops", pop_cnt, 12 - FIRST_LAT);
        check_val("stream_first_pc", first_pop_pc, RST_PC);

        // Decode stalled: credits cap requests at DEPTH
        out_ready = 1'b0;
        do_reset();
        repeat (10) step();
        check_val("stall_hs_cap", hs_cnt, DEPTH);
        check_val("stall_req_valid", 32'(imem_req_valid), 0);
        check_val("stall_instr_valid", 32'(instr_valid), 1);
        check_val("stall_head_pc", instr_pc, RST_PC);
        hs_cnt    = 0;
        out_ready = 1'b1;
        repeat (4) step();
        check_val("resume_addr", hs_first_addr, 32'h10);
        repeat (10) step();

        // Redirect coinciding with a response and a dequeue
        mem_lat = 1;
        do_reset();
        repeat (6) step();
        check_val("pre_redirect_valid", 32'(instr_valid), 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        check_val("redirect_req_blocked", 32'(imem_req_valid), 0);
        pop_cnt = 0;
        step();
        check_val("flush_empty", 32'(instr_valid), 0);
        repeat (8) step();
        check_val("redirect_first_pc", first_pop_pc, 32'h200);

        // PC wraps at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        wrap_seen      = 1'b0;
        step();
        repeat (10) step();
        check_val("wrap_seen", 32'(wrap_seen), 1);

        // Stale responses dropped after a redirect
        redirect_with_two_outstanding(32'h100);
        check_val("drain_req0", 32'(imem_req_valid), 0);
        check_val("drain_instr_valid", 32'(instr_valid), 0);
        step();
        check_val("drain_req1", 32'(imem_req_valid), 0);
        step();
        check_val("post_drain_req", 32'(imem_req_valid), 1);
        check_val("post_drain_addr", imem_req_addr, 32'h100);
        repeat (12) step();
        check_val("drain_first_pc", first_pop_pc, 32'h100);

        // Reset while draining restarts at the reset PC
        redirect_with_two_outstanding(32'h300);
        do_reset();
        mem_lat = 1;
        repeat (6) step();
        check_val("restart_addr", hs_first_addr, RST_PC);
        check_val("restart_first_pc", first_pop_pc, RST_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
